cyq_ssd2: RTL and testbench

Four-digit multiplexed seven-segment display driver that scrolls a fixed 12-symbol message (digit string 3122008883 followed by two blanks) right-to-left across a common-cathode display. It sits at the top of the display lab design, is driven by the board clock and an active-low clear, and directly drives segment lines a–g and digit enables COM_1..COM_4.

---
 rtl/cyq_ssd_pkg.sv | 60 ++++++
 rtl/cyq_seg7_dec.sv | 28 ++
 rtl/cyq_ssd2.sv | 89 ++++++++
 tb/tb_cyq_ssd2.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cyq_ssd_pkg.sv
// Shared symbol encoding, segment codes and message ROM for the scrolling
// seven-segment display blocks.
package cyq_ssd_pkg;

  typedef logic [3:0] sym_t;
  // Segment vector ordered {g,f,e,d,c,b,a}, active-high.
  typedef logic [6:0] seg_t;

  typedef struct packed {
    seg_t       seg;
    logic [3:0] com_n;   // {COM_4,COM_3,COM_2,COM_1}, active-low
  } disp_t;

  localparam sym_t SYM_BLANK = 4'hF;

  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  localparam int MSG_LEN = 12;

  localparam disp_t DISP_OFF = '{seg: SEG_BLANK, com_n: 4'b1111};

  // Message ring: 3122008883 followed by two blanks.
  function automatic sym_t msg_rom(input logic [3:0] idx);
    sym_t sym;
    case (idx)
      4'd0:    sym = 4'd3;
      4'd1:    sym = 4'd1;
      4'd2:    sym = 4'd2;
      4'd3:    sym = 4'd2;
      4'd4:    sym = 4'd0;
      4'd5:    sym = 4'd0;
      4'd6:    sym = 4'd8;
      4'd7:    sym = 4'd8;
      4'd8:    sym = 4'd8;
      4'd9:    sym = 4'd3;
      default: sym = SYM_BLANK;
    endcase
    return sym;
  endfunction

  // (offset + digit) mod MSG_LEN; offset is always < MSG_LEN.
  function automatic logic [3:0] msg_index(input logic [3:0] offset,
                                           input logic [1:0] digit);
    logic [4:0] sum;
    sum = {1'b0, offset} + {3'b000, digit};
    if (sum >= 5'(MSG_LEN)) sum = sum - 5'(MSG_LEN);
    return sum[3:0];
  endfunction

endpackage

// File: rtl/cyq_seg7_dec.sv
// Combinational 4-bit symbol to seven-segment decoder (common cathode).
// Symbols outside 0-9 render as blank.
module cyq_seg7_dec
  import cyq_ssd_pkg::*;
(
  input  logic [3:0] sym,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    seg = SEG_BLANK;
    case (sym)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cyq_ssd2.sv
// Four-digit multiplexed seven-segment driver scrolling a fixed 12-symbol
// message right-to-left; segments and digit enables are fully registered.
module cyq_ssd2
  import cyq_ssd_pkg::*;
#(
  parameter int SCAN_DIV      = 8,
  parameter int SCROLL_FRAMES = 4
) (
  input  logic Clk,
  input  logic Aclr,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic COM_1,
  output logic COM_2,
  output logic COM_3,
  output logic COM_4
);

  localparam int SC_W = $clog2(SCAN_DIV);
  localparam int FC_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [SC_W-1:0] SC_MAX   = SC_W'(SCAN_DIV - 1);
  localparam logic [FC_W-1:0] FC_MAX   = FC_W'(SCROLL_FRAMES - 1);
  localparam logic [3:0]      MSG_LAST = 4'(MSG_LEN - 1);

  logic [SC_W-1:0] sc_q, sc_d;
  logic [1:0]      di_q, di_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic [3:0]      p_q,  p_d;
  disp_t           disp_q, disp_d;

  logic sc_wrap, di_wrap, fc_wrap;
  sym_t cur_sym;
  seg_t cur_seg;

  // Cascade of wrap strobes: scan -> digit -> frame -> scroll offset.
  always_comb begin
    sc_wrap = (sc_q == SC_MAX);
    di_wrap = sc_wrap && (di_q == 2'd3);
    fc_wrap = di_wrap && (fc_q == FC_MAX);

    sc_d = sc_wrap ? '0 : sc_q + 1'b1;
    di_d = sc_wrap ? di_q + 2'd1 : di_q;

    fc_d = fc_q;
    if (di_wrap) fc_d = (fc_q == FC_MAX) ? '0 : fc_q + 1'b1;

    p_d = p_q;
    if (fc_wrap) p_d = (p_q == MSG_LAST) ? 4'd0 : p_q + 4'd1;
  end

  assign cur_sym = msg_rom(msg_index(p_q, di_q));

  cyq_seg7_dec u_dec (
    .sym (cur_sym),
    .seg (cur_seg)
  );

  // Segments and COM select come from the same state, so they switch together.
  always_comb begin
    disp_d.seg   = cur_seg;
    disp_d.com_n = ~(4'b0001 << di_q);
  end

  always_ff @(posedge Clk or negedge Aclr) begin
    if (!Aclr) begin
      sc_q   <= '0;
      di_q   <= '0;
      fc_q   <= '0;
      p_q    <= '0;
      disp_q <= DISP_OFF;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values.
      sc_q   <= sc_d;
      di_q   <= di_d;
      fc_q   <= fc_d;
      p_q    <= p_d;
      disp_q <= disp_d;
    end
  end

  assign {g, f, e, d, c, b, a}        = disp_q.seg;
  assign {COM_4, COM_3, COM_2, COM_1} = disp_q.com_n;

endmodule

// File: tb/tb_cyq_ssd2.sv
// Self-checking bench for cyq_ssd2: arithmetic reference model driven by
// elapsed cycle count, random run lengths and random asynchronous clears.
module tb_cyq_ssd2;

  localparam int SD   = 8;
  localparam int SF   = 4;
  localparam int STEP = 4 * SD * SF;

  logic Clk;
  logic Aclr;
  logic a, b, c, d, e, f, g;
  logic COM_1, COM_2, COM_3, COM_4;

  int tests = 0;
  int fails = 0;
  int n     = 0;   // rising edges since the last release of Aclr

  int msg_tb    [12]   = '{3, 1, 2, 2, 0, 0, 8, 8, 8, 3, 15, 15};
  int dir_steps [5]    = '{1, 2, 9, 11, 12};
  int dir_tab   [5][4] = '{'{1, 2, 2, 0},
                           '{2, 2, 0, 0},
                           '{3, 15, 15, 3},
                           '{15, 3, 1, 2},
                           '{3, 1, 2, 2}};

  cyq_ssd2 #(
    .SCAN_DIV      (SD),
    .SCROLL_FRAMES (SF)
  ) dut (
    .Clk   (Clk),
    .Aclr  (Aclr),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .COM_1 (COM_1),
    .COM_2 (COM_2),
    .COM_3 (COM_3),
    .COM_4 (COM_4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Segment table {g,f,e,d,c,b,a}; 15 is the blank symbol.
  function automatic logic [6:0] seg_of(input int sym);
    case (sym)
      0:       return 7'b0111111;
      1:       return 7'b0000110;
      2:       return 7'b1011011;
      3:       return 7'b1001111;
      4:       return 7'b1100110;
      5:       return 7'b1101101;
      6:       return 7'b1111101;
      7:       return 7'b0000111;
      8:       return 7'b1111111;
      9:       return 7'b1101111;
      15:      return 7'b0000000;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (t=%0t n=%0d)", tag, obs, exp, $time, n);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_com"}, 11'({COM_4, COM_3, COM_2, COM_1}), 11'(4'b1111));
    check({tag, "_seg"}, 11'({g, f, e, d, c, b, a}), 11'(7'b0000000));
  endtask

  // One clock of normal operation compared against the elapsed-time model.
  task automatic step_check();
    int t, digit, p;
    logic [6:0] eseg, oseg;
    logic [3:0] ecom, ocom;
    @(posedge Clk);
    #1;
    n++;
    t     = n - 1;
    digit = (t / SD) % 4;
    p     = (t / STEP) % 12;
    eseg  = seg_of(msg_tb[(p + digit) % 12]);
    ecom  = ~(4'b0001 << digit);
    oseg  = {g, f, e, d, c, b, a};
    ocom  = {COM_4, COM_3, COM_2, COM_1};
    check("com", 11'(ocom), 11'(ecom));
    check("seg", 11'(oseg), 11'(eseg));
    check("onehot_known", 11'($onehot(~ocom) && !$isunknown({oseg, ocom})), 11'd1);
    if (t % SD == 0) begin
      for (int i = 0; i < 5; i++) begin
        if (t / STEP == dir_steps[i])
          check($sformatf("frame_step%0d_dig%0d", dir_steps[i], digit),
                11'(oseg), 11'(seg_of(dir_tab[i][digit])));
      end
    end
  endtask

  // Clear mid-cycle, confirm immediate effect, hold, then release on a falling edge.
  task automatic async_clear(input int hold);
    #2;
    Aclr = 1'b0;
    #1;
    check_reset("async_clr");
    repeat (hold) begin
      @(posedge Clk);
      #1;
      check_reset("clr_hold");
    end
    @(negedge Clk);
    Aclr = 1'b1;
    n = 0;
  endtask

  initial begin
    Aclr = 1'b0;

    repeat (50) begin
      @(posedge Clk);
      #1;
      check_reset("rst_hold");
    end
    @(negedge Clk);
    Aclr = 1'b1;
    n = 0;

    // Covers first frame, scroll steps, wrap-around and the one-hot property.
    repeat (2000) step_check();

    // Reset mid-scroll while the offset is 5.
    for (int guard = 0; guard < 12 * STEP + 1; guard++) begin
      if (((n - 1) / STEP) % 12 == 5) break;
      step_check();
    end
    repeat ($urandom_range(0, 100)) step_check();
    async_clear(3);
    repeat (300) step_check();

    // Random run lengths and clear pulse widths.
    repeat (4) begin
      repeat ($urandom_range(1, 900)) step_check();
      async_clear($urandom_range(1, 5));
    end
    repeat (200) step_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
